// File: rtl/alu_op_issuer.sv
// alu_op_issuer: accepts one encoded ALU op, raises that op's one-hot strobe
// for its settle time, captures the 64-bit ALU result into the Z pair and
// pulses done. Illegal opcodes and divide-by-zero are screened before any
// strobe is raised.
module alu_op_issuer #(
  parameter int unsigned BASE_CYCLES = 1,  // hold for all ops but MUL/DIV, 1..15
  parameter int unsigned MUL_CYCLES  = 2,  // hold for MUL, 1..15
  parameter int unsigned DIV_CYCLES  = 4   // hold for DIV, 1..15
) (
  input  logic        clock,
  input  logic        clear,        // synchronous, active-low
  input  logic        op_valid,
  input  logic [3:0]  op_code,
  input  logic [31:0] b_operand,
  output logic        op_ready,
  output logic [12:0] op_strobe,
  input  logic [63:0] alu_out,
  output logic [31:0] z_hi,
  output logic [31:0] z_lo,
  output logic        done,
  output logic        err_illegal,
  output logic        div_by_zero
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_DONE
  } state_e;

  localparam logic [3:0] OP_MUL  = 4'd2;
  localparam logic [3:0] OP_DIV  = 4'd3;
  localparam logic [3:0] OP_LAST = 4'd12;  // highest legal opcode (NOT)

  state_e      state_q, state_d;
  logic [3:0]  op_q,    op_d;
  logic [3:0]  cnt_q,   cnt_d;
  logic [31:0] z_hi_q,  z_hi_d;
  logic [31:0] z_lo_q,  z_lo_d;
  logic        err_q,   err_d;
  logic        dbz_q,   dbz_d;

  // Strobe hold length for an opcode, already reduced by one for the counter.
  function automatic logic [3:0] hold_minus_one(input logic [3:0] code);
    logic [3:0] n;
    case (code)
      OP_MUL:  n = 4'(MUL_CYCLES);
      OP_DIV:  n = 4'(DIV_CYCLES);
      default: n = 4'(BASE_CYCLES);
    endcase
    return n - 4'd1;
  endfunction

  // State and datapath registers; clear wins over every other update.
  always_ff @(posedge clock) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge values computed by the combinational block.
    if (!clear) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      cnt_q   <= '0;
      z_hi_q  <= '0;
      z_lo_q  <= '0;
      err_q   <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      z_hi_q  <= z_hi_d;
      z_lo_q  <= z_lo_d;
      err_q   <= err_d;
      dbz_q   <= dbz_d;
    end
  end

  // Next-state logic: accept/screen in IDLE, count down and capture in EXEC.
  always_comb begin
    // NOTE: every output of this block gets a hold-value default first, so no
    // path through the case statement can infer a latch.
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    z_hi_d  = z_hi_q;
    z_lo_d  = z_lo_q;
    err_d   = err_q;
    dbz_d   = dbz_q;

    case (state_q)
      ST_IDLE: begin
        if (op_valid) begin
          op_d  = op_code;
          err_d = 1'b0;
          dbz_d = 1'b0;
          if (op_code > OP_LAST) begin
            err_d   = 1'b1;
            state_d = ST_DONE;
          end else if (op_code == OP_DIV && b_operand == 32'd0) begin
            dbz_d   = 1'b1;
            z_hi_d  = '0;
            z_lo_d  = '0;
            state_d = ST_DONE;
          end else begin
            cnt_d   = hold_minus_one(op_code);
            state_d = ST_EXEC;
          end
        end
      end

      ST_EXEC: begin
        if (cnt_q == 4'd0) begin
          // Only MUL/DIV produce a meaningful upper word.
          z_hi_d  = (op_q == OP_MUL || op_q == OP_DIV) ? alu_out[63:32] : 32'd0;
          z_lo_d  = alu_out[31:0];
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs decode directly from the registered state.
  always_comb begin
    op_strobe = '0;
    if (state_q == ST_EXEC) op_strobe = 13'd1 << op_q;
  end

  assign op_ready    = (state_q == ST_IDLE);
  assign done        = (state_q == ST_DONE);
  assign z_hi        = z_hi_q;
  assign z_lo        = z_lo_q;
  assign err_illegal = err_q;
  assign div_by_zero = dbz_q;

endmodule
